pattern_counter: RTL and testbench
==================================

Name: pattern_counter

Overview:
- Serial bit-stream pattern detector. Shifts in one bit per enabled clock and compares the most recent PATTERN_WIDTH bits against a programmable pattern.
- Counts every match. Overlapping matches count separately.
- Sits on a serial data path as a statistics/monitor block and feeds a status register file.

Parameters:
- PATTERN_WIDTH, 4, length in bits of the pattern and of the sliding window.
- COUNT_WIDTH, 16, width of match_count.

Ports:
- clk, input, 1, rising-edge clock for all state.
- rst, input, 1, asynchronous active-low reset (0 = reset).
- bit_in, input, 1, serial data bit, sampled when enable=1.
- pattern, input, PATTERN_WIDTH, pattern to detect. MSB is compared with the oldest bit of the window. Sampled every cycle.
- enable, input, 1, bit-valid qualifier. One bit is consumed per clock while high.
- match_count, output, COUNT_WIDTH, number of matches since reset.
- pattern_match, output, 1, one-cycle pulse for a match on the last consumed bit.
- ready, output, 1, high once the window holds PATTERN_WIDTH valid bits.

Behaviour:
- Reset (rst=0, asynchronous assert, synchronous release at clk edge):
  - window shift register = 0, fill counter = 0.
  - match_count = 0, pattern_match = 0, ready = 0.
- Clock edge with enable=1:
  - next_window = {window[PATTERN_WIDTH-2:0], bit_in}. Newest bit goes in the LSB.
  - Fill counter increments, saturating at PATTERN_WIDTH.
  - A match is (fill >= PATTERN_WIDTH-1 before this edge) AND (next_window == pattern).
  - On a match, match_count increments and pattern_match = 1 for exactly the next cycle. Otherwise pattern_match = 0.
- Clock edge with enable=0:
  - Window, fill counter and match_count hold.
  - pattern_match = 0.
- Latency: match_count and pattern_match reflect bit N from the cycle after the edge that consumed bit N. All outputs are registered.
- ready = (fill counter == PATTERN_WIDTH). It rises after the PATTERN_WIDTH-th consumed bit and stays high until reset.
- Fewer than PATTERN_WIDTH bits consumed: no match is possible, even if the zero-filled window equals the pattern. Example: pattern 0000 does not match on the 1st–3rd bits.
- Overlap: every window position is evaluated. Example: 10 consecutive 1s against pattern 1111 gives 7 matches.
- Pattern change mid-stream: the new value applies from the next enabled edge. The window is not cleared.
- enable gaps do not break the stream. Bits either side of a gap are treated as contiguous.
- Counter overflow: match_count wraps modulo 2^COUNT_WIDTH unless the optional feature below is compiled in.
- Reset asserted mid-stream clears everything immediately. No match is counted on that edge.

Optional Feature:
- Macro: PATTERN_COUNTER_SATURATE_EN.
- Defined: match_count saturates at all-ones (2^COUNT_WIDTH-1). Further matches still pulse pattern_match but do not change the count.
- Undefined: match_count wraps to 0 after all-ones.

Test Plan:
- pattern=1010, feed 1101010101 (MSB first, enable high 10 cycles) -> match_count=3, ready=1, pattern_match pulses 3 times.
- pattern=1111, feed 1010101010 -> match_count=0, pattern_match never high. Then feed 1111111111 after reset -> match_count=7.
- pattern=0000, feed 10 zeros -> match_count=7, first pattern_match the cycle after the 4th bit. pattern=0001, feed 0000000001 -> match_count=1.
- pattern=1010, feed only 101 -> match_count=0, ready=0. pattern=1001, feed 00001001 -> match_count=1 on the last bit.
- Enable gaps: feed 10, drop enable 3 cycles, feed 10 with pattern=1010 -> match_count=1. Assert rst mid-stream -> all outputs 0 asynchronously, before the next clock edge.
- Force match_count near all-ones via a long stream with pattern=0000, then continue feeding -> wraps to 0 without the macro; holds at 0xFFFF with PATTERN_COUNTER_SATURATE_EN.

Source files
------------

// File: rtl/pattern_counter.sv
// Serial pattern detector: slides a PATTERN_WIDTH-bit window over bit_in and counts every (overlapping) match.
// Define PATTERN_COUNTER_SATURATE_EN to make match_count stick at all-ones instead of wrapping.
module pattern_counter #(
    parameter int PATTERN_WIDTH = 4,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bit_in,
    input  logic [PATTERN_WIDTH-1:0] pattern,
    input  logic                     enable,
    output logic [COUNT_WIDTH-1:0]   match_count,
    output logic                     pattern_match,
    output logic                     ready
);

    localparam int                FILL_W    = $clog2(PATTERN_WIDTH + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_WIDTH);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);

    logic [PATTERN_WIDTH-1:0] window;
    logic [PATTERN_WIDTH-1:0] next_window;
    logic [FILL_W-1:0]        fill;
    logic [FILL_W-1:0]        next_fill;
    logic [COUNT_WIDTH-1:0]   next_count;
    logic                     hit;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned and infers a latch.
    always_comb begin
        next_window = {window[PATTERN_WIDTH-2:0], bit_in};
        next_fill   = (fill == FILL_FULL) ? fill : fill + FILL_ONE;
        // The window only becomes trustworthy once it will hold PATTERN_WIDTH real bits after this edge.
        hit         = enable && (fill >= FILL_FULL - FILL_ONE) && (next_window == pattern);
        next_count  = match_count;
`ifdef PATTERN_COUNTER_SATURATE_EN
        if (hit && (match_count != {COUNT_WIDTH{1'b1}})) begin
            next_count = match_count + COUNT_WIDTH'(1);
        end
`else
        if (hit) begin
            next_count = match_count + COUNT_WIDTH'(1);
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            window        <= '0;
            fill          <= '0;
            match_count   <= '0;
            pattern_match <= 1'b0;
            ready         <= 1'b0;
        end else begin
            pattern_match <= hit;
            match_count   <= next_count;
            if (enable) begin
                window <= next_window;
                fill   <= next_fill;
                ready  <= (next_fill == FILL_FULL);
            end
        end
    end

endmodule

// File: tb/tb_pattern_counter.sv
// Directed self-checking bench for pattern_counter: matching, overlap, fill gating, enable gaps,
// asynchronous reset and count wrap/saturation (on a narrow-counter instance).
module tb_pattern_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic        bit_in;
    logic [3:0]  pattern;
    logic        enable;
    logic [15:0] match_count;
    logic        pattern_match;
    logic        ready;

    // Narrow instance so counter overflow is reachable in a few cycles.
    logic        s_bit_in;
    logic [3:0]  s_pattern;
    logic        s_enable;
    logic [3:0]  s_count;
    logic        s_match;
    logic        s_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pattern_counter #(.PATTERN_WIDTH(4), .COUNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .pattern(pattern), .enable(enable),
        .match_count(match_count), .pattern_match(pattern_match), .ready(ready)
    );

    pattern_counter #(.PATTERN_WIDTH(4), .COUNT_WIDTH(4)) dut_small (
        .clk(clk), .rst(rst), .bit_in(s_bit_in), .pattern(s_pattern), .enable(s_enable),
        .match_count(s_count), .pattern_match(s_match), .ready(s_ready)
    );

    // Feed n bits MSB first, one per cycle; count pattern_match pulses, return the pulse for the last bit.
    task automatic feed(input logic [31:0] bits, input int n, output int pulses, output logic last_pm);
        pulses = 0;
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            if (pattern_match) pulses++;
            bit_in = bits[i];
            enable = 1'b1;
        end
        @(negedge clk);
        last_pm = pattern_match;
        if (pattern_match) pulses++;
        enable = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst      = 1'b0;
        enable   = 1'b0;
        s_enable = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (match_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", match_count); end
        checks++;
        if (pattern_match !== 1'b0) begin errors++; $display("FAIL reset_match got %b want 0", pattern_match); end
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready); end
    endtask

    task automatic test_basic();
        int p; logic lp;
        apply_reset();
        pattern = 4'b1010;
        feed(32'b1101010101, 10, p, lp);
        checks++;
        if (match_count !== 16'd3) begin errors++; $display("FAIL basic_count got %0d want 3", match_count); end
        checks++;
        if (p !== 3) begin errors++; $display("FAIL basic_pulses got %0d want 3", p); end
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %b want 1", ready); end
    endtask

    task automatic test_no_match_and_overlap();
        int p; logic lp;
        apply_reset();
        pattern = 4'b1111;
        feed(32'b1010101010, 10, p, lp);
        checks++;
        if (match_count !== 16'd0) begin errors++; $display("FAIL nomatch_count got %0d want 0", match_count); end
        checks++;
        if (p !== 0) begin errors++; $display("FAIL nomatch_pulses got %0d want 0", p); end
        apply_reset();
        feed(32'b1111111111, 10, p, lp);
        checks++;
        if (match_count !== 16'd7) begin errors++; $display("FAIL overlap_count got %0d want 7", match_count); end
        checks++;
        if (p !== 7) begin errors++; $display("FAIL overlap_pulses got %0d want 7", p); end
    endtask

    task automatic test_zero_pattern();
        int p; logic lp;
        apply_reset();
        pattern = 4'b0000;
        feed(32'b000, 3, p, lp);
        checks++;
        if (match_count !== 16'd0 || p !== 0) begin
            errors++; $display("FAIL zero_early got count %0d pulses %0d want 0 0", match_count, p);
        end
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL zero_ready_early got %b want 0", ready); end
        feed(32'b0, 1, p, lp);
        checks++;
        if (lp !== 1'b1) begin errors++; $display("FAIL zero_first_pulse got %b want 1", lp); end
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL zero_ready got %b want 1", ready); end
        feed(32'b0, 6, p, lp);
        checks++;
        if (match_count !== 16'd7) begin errors++; $display("FAIL zero_count got %0d want 7", match_count); end
        apply_reset();
        pattern = 4'b0001;
        feed(32'b0000000001, 10, p, lp);
        checks++;
        if (match_count !== 16'd1 || lp !== 1'b1) begin
            errors++; $display("FAIL p0001 got count %0d last %b want 1 1", match_count, lp);
        end
    endtask

    task automatic test_partial();
        int p; logic lp;
        apply_reset();
        pattern = 4'b1010;
        feed(32'b101, 3, p, lp);
        checks++;
        if (match_count !== 16'd0 || ready !== 1'b0) begin
            errors++; $display("FAIL partial got count %0d ready %b want 0 0", match_count, ready);
        end
        apply_reset();
        pattern = 4'b1001;
        feed(32'b0000100, 7, p, lp);
        checks++;
        if (match_count !== 16'd0) begin errors++; $display("FAIL p1001_pre got %0d want 0", match_count); end
        feed(32'b1, 1, p, lp);
        checks++;
        if (match_count !== 16'd1 || lp !== 1'b1) begin
            errors++; $display("FAIL p1001_last got count %0d pulse %b want 1 1", match_count, lp);
        end
    endtask

    task automatic test_enable_gap();
        int p; logic lp;
        apply_reset();
        pattern = 4'b1010;
        feed(32'b10, 2, p, lp);
        for (int i = 0; i < 3; i++) begin
            bit_in = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (pattern_match !== 1'b0 || match_count !== 16'd0) begin
            errors++; $display("FAIL gap_hold got match %b count %0d want 0 0", pattern_match, match_count);
        end
        feed(32'b10, 2, p, lp);
        checks++;
        if (match_count !== 16'd1 || lp !== 1'b1) begin
            errors++; $display("FAIL gap_count got count %0d pulse %b want 1 1", match_count, lp);
        end
    endtask

    task automatic test_async_reset();
        int p; logic lp;
        apply_reset();
        pattern = 4'b1111;
        feed(32'b11111, 5, p, lp);
        @(negedge clk);
        bit_in = 1'b1;
        enable = 1'b1;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (match_count !== 16'd0 || pattern_match !== 1'b0 || ready !== 1'b0) begin
            errors++; $display("FAIL async_reset got count %0d match %b ready %b want 0 0 0",
                               match_count, pattern_match, ready);
        end
        @(negedge clk);
        enable = 1'b0;
        rst = 1'b1;
        checks++;
        if (match_count !== 16'd0) begin errors++; $display("FAIL reset_edge_count got %0d want 0", match_count); end
    endtask

    task automatic test_overflow();
        logic [3:0] exp_wrap;
        apply_reset();
        s_pattern = 4'b0000;
        s_bit_in  = 1'b0;
        @(negedge clk);
        s_enable = 1'b1;
        repeat (18) @(negedge clk);
        s_enable = 1'b0;
        checks++;
        if (s_count !== 4'hF) begin errors++; $display("FAIL ovf_full got %0d want 15", s_count); end
        s_enable = 1'b1;
        @(negedge clk);
        s_enable = 1'b0;
`ifdef PATTERN_COUNTER_SATURATE_EN
        exp_wrap = 4'hF;
`else
        exp_wrap = 4'h0;
`endif
        checks++;
        if (s_count !== exp_wrap) begin errors++; $display("FAIL ovf_wrap got %0d want %0d", s_count, exp_wrap); end
        checks++;
        if (s_match !== 1'b1) begin errors++; $display("FAIL ovf_pulse got %b want 1", s_match); end
    endtask

    initial begin
        rst       = 1'b1;
        bit_in    = 1'b0;
        enable    = 1'b0;
        pattern   = 4'b0000;
        s_bit_in  = 1'b0;
        s_enable  = 1'b0;
        s_pattern = 4'b0000;
        test_reset();
        test_basic();
        test_no_match_and_overlap();
        test_zero_pattern();
        test_partial();
        test_enable_gap();
        test_async_reset();
        test_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
